instruction_fetch_stage: RTL and testbench

- IF stage of the 5-stage MIPS pipeline.
- Holds the PC and a loadable instruction memory, and drives the IF/ID register that the decode stage consumes (o_pc = PC+4, o_instruction).
- Handles stall (hazard unit), redirect (jump/branch resolution) and program halt.
- Programs are loaded word-by-word from the debug unit through a write port.

---
 rtl/pipeline_pkg.sv | 11 +
 rtl/instruction_memory.sv | 35 +++
 rtl/instruction_fetch_stage.sv | 112 +++++++++++
 tb/tb_instruction_fetch_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: special instruction encodings and PC reset/increment values.
package pipeline_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned PC_INCR  = 4;
  localparam int unsigned RESET_PC = 0;

  localparam logic [INSTR_W-1:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage : pipeline_pkg

// File: rtl/instruction_memory.sv
// Instruction memory: MEM_DEPTH x 32 words, combinational read, synchronous write.
// Contents are never reset; programs are loaded through the write port.
//   i_clk       clock
//   i_wr_en     write strobe
//   i_wr_addr   word address to write
//   i_wr_data   word to write
//   i_rd_addr   word address to read
//   o_rd_data_c read data (combinational; a same-cycle write is not visible)
module instruction_memory
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [INSTR_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic [INSTR_W-1:0] o_rd_data_c
);

  logic [INSTR_W-1:0] mem [MEM_DEPTH];

  // Program-load write port
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Asynchronous fetch port
  assign o_rd_data_c = mem[i_rd_addr];

endmodule : instruction_memory

// File: rtl/instruction_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC, instruction memory and IF/ID register.
// Handles stall, redirect (taken branch/jump) and sticky halt on a fetched HALT word.
//   i_clk          clock
//   i_rst          asynchronous active-high reset
//   i_enable       run enable; 0 freezes the whole stage including redirect
//   i_stall        hazard stall; holds PC and IF/ID
//   i_flg_pc_src   redirect request
//   i_pc_target    redirect byte address (low two bits ignored)
//   i_mem_wr_en    program-load write strobe
//   i_mem_wr_addr  program-load word address
//   i_mem_wr_data  program-load instruction word
//   o_fetch_pc     current PC
//   o_pc           IF/ID: PC+4 of the held instruction
//   o_instruction  IF/ID: held instruction
//   o_valid        IF/ID holds a real instruction
//   o_halted       HALT fetched; fetch stopped until redirect or reset
module instruction_fetch_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned NBITS     = 32,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_flg_pc_src,
  input  logic [NBITS-1:0]   i_pc_target,
  input  logic               i_mem_wr_en,
  input  logic [ADDR_W-1:0]  i_mem_wr_addr,
  input  logic [INSTR_W-1:0] i_mem_wr_data,
  output logic [NBITS-1:0]   o_fetch_pc,
  output logic [NBITS-1:0]   o_pc,
  output logic [INSTR_W-1:0] o_instruction,
  output logic               o_valid,
  output logic               o_halted
);

  logic [NBITS-1:0]   pc_q;
  logic [NBITS-1:0]   pc_d;
  logic [NBITS-1:0]   pc_plus4;
  logic [NBITS-1:0]   ifid_pc_d;
  logic [INSTR_W-1:0] ifid_instr_d;
  logic               valid_d;
  logic               halted_d;
  logic [INSTR_W-1:0] fetch_word;
  logic               redirect;
  logic               adv;

  instruction_memory #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_imem (
    .i_clk       (i_clk),
    .i_wr_en     (i_mem_wr_en),
    .i_wr_addr   (i_mem_wr_addr),
    .i_wr_data   (i_mem_wr_data),
    .i_rd_addr   (pc_q[ADDR_W+1:2]),
    .o_rd_data_c (fetch_word)
  );

  assign pc_plus4 = pc_q + NBITS'(PC_INCR);
  assign redirect = i_enable & i_flg_pc_src;
  assign adv      = i_enable & ~i_stall & ~o_halted;

  // Next-state: redirect beats freeze beats advance
  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = o_pc;
    ifid_instr_d = o_instruction;
    valid_d      = o_valid;
    halted_d     = o_halted;
    if (redirect) begin
      // Wrong-path work, including a fetched HALT, is discarded
      pc_d         = i_pc_target & ~NBITS'(3);
      ifid_instr_d = NOP_WORD;
      valid_d      = 1'b0;
      halted_d     = 1'b0;
    end else if (adv) begin
      ifid_instr_d = fetch_word;
      ifid_pc_d    = pc_plus4;
      valid_d      = 1'b1;
      // HALT still drains down the pipe; PC parks on it
      if (fetch_word == HALT_WORD) begin
        halted_d = 1'b1;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  // PC and IF/ID registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q          <= NBITS'(RESET_PC);
      o_pc          <= NBITS'(RESET_PC);
      o_instruction <= NOP_WORD;
      o_valid       <= 1'b0;
      o_halted      <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      o_pc          <= ifid_pc_d;
      o_instruction <= ifid_instr_d;
      o_valid       <= valid_d;
      o_halted      <= halted_d;
    end
  end

  assign o_fetch_pc = pc_q;

endmodule : instruction_fetch_stage

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

  localparam int unsigned NBITS     = 32;
  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_enable;
  logic              i_stall;
  logic              i_flg_pc_src;
  logic [NBITS-1:0]  i_pc_target;
  logic              i_mem_wr_en;
  logic [ADDR_W-1:0] i_mem_wr_addr;
  logic [31:0]       i_mem_wr_data;
  logic [NBITS-1:0]  o_fetch_pc;
  logic [NBITS-1:0]  o_pc;
  logic [31:0]       o_instruction;
  logic              o_valid;
  logic              o_halted;

  instruction_fetch_stage #(
    .NBITS     (NBITS),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_enable      (i_enable),
    .i_stall       (i_stall),
    .i_flg_pc_src  (i_flg_pc_src),
    .i_pc_target   (i_pc_target),
    .i_mem_wr_en   (i_mem_wr_en),
    .i_mem_wr_addr (i_mem_wr_addr),
    .i_mem_wr_data (i_mem_wr_data),
    .o_fetch_pc    (o_fetch_pc),
    .o_pc          (o_pc),
    .o_instruction (o_instruction),
    .o_valid       (o_valid),
    .o_halted      (o_halted)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [31:0] W0   = 32'h2001_0005;
  localparam logic [31:0] W1   = 32'h2002_0007;
  localparam logic [31:0] W2   = 32'h0022_1820;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] W4   = 32'h4444_4444;
  localparam logic [31:0] W16  = 32'h1111_1111;
  localparam logic [31:0] W17  = 32'h2222_2222;
  localparam logic [31:0] W255 = 32'hAAAA_0255;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] fpc;
    logic        v;
    logic        h;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] fpc,
                      input logic v, input logic h);
    exp_t e;
    e.ins = ins; e.pc = pc; e.fpc = fpc; e.v = v; e.h = h;
    sb.push_back(e);
  endtask

  // One clock edge, then pop the expectation and compare every IF output
  task automatic step(input string tag);
    exp_t e;
    @(posedge i_clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, ".instr"},    o_instruction,  e.ins);
      chk({tag, ".pc"},       o_pc,           e.pc);
      chk({tag, ".fetch_pc"}, o_fetch_pc,     e.fpc);
      chk({tag, ".valid"},    32'(o_valid),   32'(e.v));
      chk({tag, ".halted"},   32'(o_halted),  32'(e.h));
    end
  endtask

  task automatic check_reset_now(input string tag);
    chk({tag, ".instr"},    o_instruction, 32'h0);
    chk({tag, ".pc"},       o_pc,          32'h0);
    chk({tag, ".fetch_pc"}, o_fetch_pc,    32'h0);
    chk({tag, ".valid"},    32'(o_valid),  32'h0);
    chk({tag, ".halted"},   32'(o_halted), 32'h0);
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    i_mem_wr_en   = 1'b1;
    i_mem_wr_addr = a;
    i_mem_wr_data = d;
    @(posedge i_clk);
    #1;
    i_mem_wr_en   = 1'b0;
  endtask

  task automatic pulse_reset();
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_enable = 1'b0; i_stall = 1'b0; i_flg_pc_src = 1'b0;
    i_pc_target = '0; i_mem_wr_en = 1'b0; i_mem_wr_addr = '0; i_mem_wr_data = '0;
    #1;
    check_reset_now("reset_init");

    load(8'd0, W0);   load(8'd1, W1);   load(8'd2, W2);   load(8'd3, HALT);
    load(8'd4, W4);   load(8'd16, W16); load(8'd17, W17); load(8'd255, W255);

    // Straight-line run into HALT
    i_rst = 1'b0; i_enable = 1'b1;
    push(W0, 4, 4, 1, 0);     step("run.e1");
    push(W1, 8, 8, 1, 0);     step("run.e2");
    push(W2, 12, 12, 1, 0);   step("run.e3");
    push(HALT, 16, 12, 1, 1); step("run.halt");
    push(HALT, 16, 12, 1, 1); step("run.halt_hold");
    i_stall = 1'b1;
    push(HALT, 16, 12, 1, 1); step("run.halt_stall");
    i_stall = 1'b0;

    // Redirect clears halt and resumes at mem[2]
    i_flg_pc_src = 1'b1; i_pc_target = 32'h8;
    push(32'h0, 16, 8, 0, 0); step("halt_redir.bubble");
    i_flg_pc_src = 1'b0;
    push(W2, 12, 12, 1, 0);   step("halt_redir.resume");
    push(HALT, 16, 12, 1, 1); step("halt_redir.halt_again");

    // Asynchronous reset mid-run, checked before any clock edge
    i_rst = 1'b1;
    #1;
    check_reset_now("reset_async");
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Stall after the second fetch
    push(W0, 4, 4, 1, 0); step("stall.e1");
    push(W1, 8, 8, 1, 0); step("stall.e2");
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(W1, 8, 8, 1, 0); step("stall.hold");
    end
    i_stall = 1'b0;
    push(W2, 12, 12, 1, 0); step("stall.resume");
    pulse_reset();

    // Redirect at PC=4 to 0x40, then redirect+stall to 0x13
    push(W0, 4, 4, 1, 0); step("redir.e1");
    i_flg_pc_src = 1'b1; i_pc_target = 32'h40;
    push(32'h0, 4, 32'h40, 0, 0); step("redir.bubble");
    i_flg_pc_src = 1'b0;
    push(W16, 32'h44, 32'h44, 1, 0); step("redir.target");
    i_flg_pc_src = 1'b1; i_stall = 1'b1; i_pc_target = 32'h13;
    push(32'h0, 32'h44, 32'h10, 0, 0); step("redir_stall.bubble");
    i_flg_pc_src = 1'b0; i_stall = 1'b0;
    push(W4, 32'h14, 32'h14, 1, 0); step("redir_stall.fetch");

    // Wrap at the top of memory
    i_flg_pc_src = 1'b1; i_pc_target = 32'(4 * MEM_DEPTH - 4);
    push(32'h0, 32'h14, 32'(4 * MEM_DEPTH - 4), 0, 0); step("wrap.bubble");
    i_flg_pc_src = 1'b0;
    push(W255, 32'(4 * MEM_DEPTH), 32'(4 * MEM_DEPTH), 1, 0);         step("wrap.last");
    push(W0, 32'(4 * MEM_DEPTH + 4), 32'(4 * MEM_DEPTH + 4), 1, 0);   step("wrap.mem0");

    // Freeze with enable=0: write current PC word, redirect is blocked
    i_enable = 1'b0; i_flg_pc_src = 1'b1; i_pc_target = 32'h80;
    i_mem_wr_en = 1'b1; i_mem_wr_addr = 8'd1; i_mem_wr_data = 32'h0BAD_C0DE;
    push(W0, 32'(4 * MEM_DEPTH + 4), 32'(4 * MEM_DEPTH + 4), 1, 0); step("freeze.e1");
    i_mem_wr_en = 1'b0;
    push(W0, 32'(4 * MEM_DEPTH + 4), 32'(4 * MEM_DEPTH + 4), 1, 0); step("freeze.e2");
    i_flg_pc_src = 1'b0; i_enable = 1'b1;
    push(32'h0BAD_C0DE, 32'(4 * MEM_DEPTH + 8), 32'(4 * MEM_DEPTH + 8), 1, 0); step("freeze.new_word");

    // Same-cycle write to the fetched address returns the old word
    i_mem_wr_en = 1'b1; i_mem_wr_addr = 8'd2; i_mem_wr_data = 32'h3333_3333;
    push(W2, 32'(4 * MEM_DEPTH + 12), 32'(4 * MEM_DEPTH + 12), 1, 0); step("wr_same.old");
    i_mem_wr_en = 1'b0;
    i_flg_pc_src = 1'b1; i_pc_target = 32'h8;
    push(32'h0, 32'(4 * MEM_DEPTH + 12), 32'h8, 0, 0); step("wr_same.bubble");
    i_flg_pc_src = 1'b0;
    push(32'h3333_3333, 12, 12, 1, 0); step("wr_same.new");

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_instruction_fetch_stage
